// File: rtl/debounce_edge_pkg.sv
// Shared constants for the debounce/edge-detect block: counter sizing helper,
// I/O library defaults and the per-sample decision type used by each filter bit.
package debounce_edge_pkg;

  localparam int DEFAULT_STABLE   = 4;
  localparam int DEFAULT_PRESCALE = 1;

  // $clog2 with a floor of one bit, so a 0..0 counter still has a legal width.
  function automatic int counter_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    SAMPLE_HOLD,
    SAMPLE_MATCH,
    SAMPLE_COUNT,
    SAMPLE_ACCEPT
  } sample_e;

endpackage

// File: rtl/debounce_edge_if.sv
// Level and pulse bundle between the debouncer and its consumer.
interface debounce_edge_if #(
  parameter int p_WIDTH = 3
);
  logic [p_WIDTH-1:0] iv_input;
  logic [p_WIDTH-1:0] ov_state;
  logic [p_WIDTH-1:0] ov_rise;
  logic [p_WIDTH-1:0] ov_fall;

  modport master (
    output iv_input,
    input  ov_state,
    input  ov_rise,
    input  ov_fall
  );

  modport slave (
    input  iv_input,
    output ov_state,
    output ov_rise,
    output ov_fall
  );
endinterface

// File: rtl/debounce_edge_bit.sv
// One bit of filter: held level, mismatch counter and registered rise/fall pulses.
// The level only moves after p_STABLE consecutive mismatching strobed samples.
module debounce_edge_bit
  import debounce_edge_pkg::*;
#(
  parameter int p_STABLE = DEFAULT_STABLE
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_strobe,
  input  logic i_in,
  output logic o_state,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CW       = counter_width(p_STABLE);
  localparam logic [CW-1:0]   CNT_LAST = CW'(p_STABLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  sample_e       sample;

  always_comb begin
    sample = SAMPLE_HOLD;
    if (i_strobe) begin
      if (i_in == state_q) begin
        sample = SAMPLE_MATCH;
      end else if (cnt_q == CNT_LAST) begin
        sample = SAMPLE_ACCEPT;
      end else begin
        sample = SAMPLE_COUNT;
      end
    end
  end

  // Pulses default low so they never outlive the cycle after acceptance.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (sample)
      SAMPLE_HOLD:  ;
      SAMPLE_MATCH: cnt_d = '0;
      SAMPLE_COUNT: cnt_d = cnt_q + CW'(1);
      SAMPLE_ACCEPT: begin
        cnt_d   = '0;
        state_d = i_in;
        rise_d  = i_in;
        fall_d  = ~i_in;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_state = state_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

  a_pulse_exclusive: assert property (@(posedge i_clk) disable iff (i_reset)
    !(rise_q && fall_q));

  a_cnt_bounded: assert property (@(posedge i_clk) disable iff (i_reset)
    cnt_q <= CNT_LAST);

endmodule

// File: rtl/debounce_edge.sv
// Per-bit debouncer with rise/fall pulses. Owns the shared sample prescaler and
// one filter per input bit; the input must already be synchronised to i_clk.
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int p_WIDTH    = 3,
  parameter int p_STABLE   = DEFAULT_STABLE,
  parameter int p_PRESCALE = DEFAULT_PRESCALE
) (
  input  logic            i_clk,
  input  logic            i_reset,
  debounce_edge_if.slave  bus
);

  localparam int            PW       = counter_width(p_PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(p_PRESCALE - 1);

  logic [PW-1:0]      pre_q, pre_d;
  logic               strobe;
  logic [p_WIDTH-1:0] state_v;
  logic [p_WIDTH-1:0] rise_v;
  logic [p_WIDTH-1:0] fall_v;

  // With p_PRESCALE=1 the counter sits at 0 == PRE_LAST, so strobe is always high.
  always_comb begin
    strobe = (pre_q == PRE_LAST);
    pre_d  = strobe ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  generate
    for (genvar gi = 0; gi < p_WIDTH; gi++) begin : g_bit
      debounce_edge_bit #(
        .p_STABLE (p_STABLE)
      ) u_bit (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_strobe (strobe),
        .i_in     (bus.iv_input[gi]),
        .o_state  (state_v[gi]),
        .o_rise   (rise_v[gi]),
        .o_fall   (fall_v[gi])
      );
    end
  endgenerate

  assign bus.ov_state = state_v;
  assign bus.ov_rise  = rise_v;
  assign bus.ov_fall  = fall_v;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: a sample-history model checks two instances (prescale 1
// and 4) every cycle, alongside directed vectors with hand-computed expectations.
module tb_debounce_edge;

  localparam int STABLE = 3;

  logic clk;
  logic rst;

  debounce_edge_if #(.p_WIDTH(3)) if_a ();
  debounce_edge_if #(.p_WIDTH(3)) if_b ();

  debounce_edge #(.p_WIDTH(3), .p_STABLE(STABLE), .p_PRESCALE(1)) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (if_a.slave)
  );

  debounce_edge #(.p_WIDTH(3), .p_STABLE(STABLE), .p_PRESCALE(4)) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (if_b.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a level is accepted once the last STABLE strobed samples taken since
  // the previous acceptance all differ from the held level.
  int         presc [2] = '{1, 4};
  int         cyc   [2];
  logic [2:0] exp_state [2];
  logic [2:0] exp_rise  [2];
  logic [2:0] exp_fall  [2];
  bit         hist [6][$];

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      cyc[m]       = 0;
      exp_state[m] = 3'b000;
      exp_rise[m]  = 3'b000;
      exp_fall[m]  = 3'b000;
    end
    for (int k = 0; k < 6; k++) hist[k].delete();
  endtask

  task automatic model_step(input int m, input logic [2:0] din);
    bit strobe;
    bit all_diff;
    int k;
    strobe = ((cyc[m] % presc[m]) == presc[m] - 1);
    cyc[m] = cyc[m] + 1;
    exp_rise[m] = 3'b000;
    exp_fall[m] = 3'b000;
    if (strobe) begin
      for (int b = 0; b < 3; b++) begin
        k = m * 3 + b;
        hist[k].push_back(din[b]);
        if (hist[k].size() > STABLE) void'(hist[k].pop_front());
        all_diff = (hist[k].size() == STABLE);
        for (int j = 0; j < hist[k].size(); j++)
          if (hist[k][j] == exp_state[m][b]) all_diff = 1'b0;
        if (all_diff) begin
          exp_state[m][b] = din[b];
          exp_rise[m][b]  = din[b];
          exp_fall[m][b]  = ~din[b];
          hist[k].delete();
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
    end else begin
      model_step(0, if_a.iv_input);
      model_step(1, if_b.iv_input);
    end
  end

  task automatic cmp_vec(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp_vec("a_state", if_a.ov_state, exp_state[0]);
    cmp_vec("a_rise",  if_a.ov_rise,  exp_rise[0]);
    cmp_vec("a_fall",  if_a.ov_fall,  exp_fall[0]);
    cmp_vec("a_excl",  if_a.ov_rise & if_a.ov_fall, 3'b000);
    cmp_vec("b_state", if_b.ov_state, exp_state[1]);
    cmp_vec("b_rise",  if_b.ov_rise,  exp_rise[1]);
    cmp_vec("b_fall",  if_b.ov_fall,  exp_fall[1]);
    cmp_vec("b_excl",  if_b.ov_rise & if_b.ov_fall, 3'b000);
  end

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    $display("[%0t] %s got %b expected %b", $time, name, act, exp);
    cmp_vec(name, act, exp);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int  n;
    bit  found;
    rst = 1'b1;
    if_a.iv_input = 3'b000;
    if_b.iv_input = 3'b000;
    wait_cycles(3);
    check("reset_state", if_a.ov_state, 3'b000);
    check("reset_pulse", if_a.ov_rise | if_a.ov_fall, 3'b000);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_state", if_a.ov_state | if_a.ov_rise | if_a.ov_fall, 3'b000);
    end

    // Single bit rising: accepted on the third edge after the change.
    if_a.iv_input = 3'b001;
    wait_cycles(2);
    check("rise_early", if_a.ov_state, 3'b000);
    @(negedge clk);
    check("rise_state", if_a.ov_state, 3'b001);
    check("rise_pulse", if_a.ov_rise, 3'b001);
    check("rise_nofall", if_a.ov_fall, 3'b000);
    @(negedge clk);
    check("rise_pulse_end", if_a.ov_rise, 3'b000);
    if_a.iv_input = 3'b000;
    wait_cycles(3);
    check("fall1_state", if_a.ov_state, 3'b000);
    check("fall1_pulse", if_a.ov_fall, 3'b001);
    wait_cycles(2);

    // Two-sample glitches never get through.
    for (int g = 0; g < 5; g++) begin
      if_a.iv_input = 3'b010;
      wait_cycles(2);
      if_a.iv_input = 3'b000;
      wait_cycles(4);
      check("glitch_state", if_a.ov_state | if_a.ov_rise, 3'b000);
    end

    // Toggling every sample keeps the level put.
    for (int t = 0; t < 10; t++) begin
      if_a.iv_input = (t % 2 == 0) ? 3'b101 : 3'b000;
      @(negedge clk);
    end
    check("toggle_state", if_a.ov_state, 3'b000);
    if_a.iv_input = 3'b000;
    wait_cycles(3);

    // All bits together up, then down.
    if_a.iv_input = 3'b111;
    wait_cycles(3);
    check("all_rise_state", if_a.ov_state, 3'b111);
    check("all_rise_pulse", if_a.ov_rise, 3'b111);
    @(negedge clk);
    check("all_rise_end", if_a.ov_rise, 3'b000);
    wait_cycles(4);
    if_a.iv_input = 3'b000;
    wait_cycles(3);
    check("all_fall_state", if_a.ov_state, 3'b000);
    check("all_fall_pulse", if_a.ov_fall, 3'b111);
    @(negedge clk);
    check("all_fall_end", if_a.ov_fall, 3'b000);

    // Prescaled instance: acceptance within 8..12 cycles, single pulse.
    if_b.iv_input = 3'b010;
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (if_b.ov_state == 3'b010) found = 1'b1;
    end
    $display("[%0t] b_latency %0d cycles", $time, n);
    n_cmp++;
    if (!found || n < 8 || n > 12) begin
      n_bad++;
      $display("FAIL b_latency: got %0d cycles (found=%0d) expected 8..12", n, found);
    end
    check("b_rise_pulse", if_b.ov_rise, 3'b010);
    @(negedge clk);
    check("b_rise_end", if_b.ov_rise, 3'b000);
    wait_cycles(8);
    check("b_hold", if_b.ov_state, 3'b010);

    // Reset mid-count suppresses the pending acceptance.
    if_a.iv_input = 3'b100;
    wait_cycles(2);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_state", if_a.ov_state, 3'b000);
    check("rst_pulse", if_a.ov_rise, 3'b000);
    rst = 1'b0;
    wait_cycles(2);
    check("post_rst_early", if_a.ov_state, 3'b000);
    @(negedge clk);
    check("post_rst_state", if_a.ov_state, 3'b100);
    check("post_rst_pulse", if_a.ov_rise, 3'b100);
    @(negedge clk);
    check("post_rst_end", if_a.ov_rise, 3'b000);
    wait_cycles(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
